// File: rtl/mdll_pkg.sv
// Shared definitions for the MDLL frequency-calibration sequencer.
// Contents:
//   DEF_N_FCAL_CNT, DEF_N_AVG_MAX_LOG2, DEF_N_TO : default widths
//   fcal_seq_state_t                             : sequencer FSM states
//   acc_width()                                  : accumulator width for a given count/avg size
package mdll_pkg;

  localparam int unsigned DEF_N_FCAL_CNT     = 10;
  localparam int unsigned DEF_N_AVG_MAX_LOG2 = 3;
  localparam int unsigned DEF_N_TO           = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StReq,
    StRel,
    StStore,
    StFin
  } fcal_seq_state_t;

  // Enough headroom to sum 2**n_avg_max_log2 samples without overflow.
  function automatic int unsigned acc_width(input int unsigned n_cnt,
                                            input int unsigned n_avg_max_log2);
    return n_cnt + n_avg_max_log2;
  endfunction

endpackage

// File: rtl/mdll_fcal_acc.sv
// Averaging accumulator for one fcal measurement series.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : clear accumulator (start of a channel)
//   i_add        : add i_val (zero-extended) into the accumulator
//   i_val        : sample to add
//   i_avg_log2   : averaging exponent applied to the output
//   o_avg        : accumulator >> i_avg_log2, truncated to N_CNT bits
module mdll_fcal_acc
  import mdll_pkg::*;
#(
  parameter int unsigned N_CNT          = DEF_N_FCAL_CNT,
  parameter int unsigned N_AVG_MAX_LOG2 = DEF_N_AVG_MAX_LOG2,
  parameter int unsigned N_AVG_W        = $clog2(N_AVG_MAX_LOG2 + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_add,
  input  logic [N_CNT-1:0]   i_val,
  input  logic [N_AVG_W-1:0] i_avg_log2,
  output logic [N_CNT-1:0]   o_avg
);

  localparam int unsigned ACC_W = acc_width(N_CNT, N_AVG_MAX_LOG2);

  logic [ACC_W-1:0] r_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + ACC_W'(i_val);
    end
  end

  assign o_avg = N_CNT'(r_acc >> i_avg_log2);

endmodule

// File: rtl/mdll_fcal_seq.sv
// Multi-channel MDLL frequency-calibration sequencer. Sweeps the channels in
// a latched mask in ascending order, runs 2**avg_log2 start/ready handshakes
// per channel and stores the averaged count, or all-ones plus err on timeout.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start, i_abort    : single-cycle sweep request / abort
//   i_ch_mask           : channels to measure (sampled at start)
//   i_avg_log2          : averaging exponent, clamped (sampled at start)
//   i_timeout_cyc       : per-phase handshake limit, 0 = none (sampled at start)
//   o_en_fcal           : one-hot enable for the channel under measurement
//   o_fcal_start        : one-hot start request
//   i_fcal_ready        : per-channel acknowledge (already synchronised)
//   i_fcal_cnt          : packed per-channel counts
//   o_result            : packed averaged counts
//   o_result_valid      : channel result updated in this sweep
//   o_err               : channel timed out in this sweep
//   o_busy, o_done      : sweep in progress / completion pulse
module mdll_fcal_seq
  import mdll_pkg::*;
#(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned N_FCAL_CNT     = DEF_N_FCAL_CNT,
  parameter int unsigned N_AVG_MAX_LOG2 = DEF_N_AVG_MAX_LOG2,
  parameter int unsigned N_TO           = DEF_N_TO,
  parameter int unsigned N_AVG_W        = $clog2(N_AVG_MAX_LOG2 + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [N_CH-1:0]            i_ch_mask,
  input  logic [N_AVG_W-1:0]         i_avg_log2,
  input  logic [N_TO-1:0]            i_timeout_cyc,
  output logic [N_CH-1:0]            o_en_fcal,
  output logic [N_CH-1:0]            o_fcal_start,
  input  logic [N_CH-1:0]            i_fcal_ready,
  input  logic [N_CH*N_FCAL_CNT-1:0] i_fcal_cnt,
  output logic [N_CH*N_FCAL_CNT-1:0] o_result,
  output logic [N_CH-1:0]            o_result_valid,
  output logic [N_CH-1:0]            o_err,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned IT_W = N_AVG_MAX_LOG2 + 1;

  fcal_seq_state_t           r_state;
  logic [N_CH-1:0]           r_mask;      // channels still to visit
  logic [CH_W-1:0]           r_ch;
  logic [N_AVG_W-1:0]        r_avg_log2;
  logic [N_TO-1:0]           r_to_thr;
  logic [N_TO-1:0]           r_to_cnt;
  logic [IT_W-1:0]           r_iter;
  logic [N_CH-1:0]           r_en_fcal;
  logic [N_CH-1:0]           r_fcal_start;
  logic [N_CH*N_FCAL_CNT-1:0] r_result;
  logic [N_CH-1:0]           r_result_valid;
  logic [N_CH-1:0]           r_err;
  logic                      r_busy;
  logic                      r_done;

  logic                      w_ff_found;
  logic [CH_W-1:0]           w_ff_ch;
  logic [N_CH-1:0]           w_ff_oh;
  logic [N_CH-1:0]           w_ch_oh;
  logic [N_AVG_W-1:0]        w_avg_clamp;
  logic [IT_W-1:0]           w_iter_nxt;
  logic [IT_W-1:0]           w_iter_tgt;
  logic [N_TO-1:0]           w_to_nxt;
  logic                      w_to_hit;
  logic                      w_rdy;
  logic [N_FCAL_CNT-1:0]     w_cnt_sel;
  logic [N_FCAL_CNT-1:0]     w_avg;
  logic                      w_acc_clr;
  logic                      w_acc_add;

  // Lowest remaining mask bit; visited bits are cleared, so this walks upward
  // and an empty remainder is seen in a single SEL cycle.
  always_comb begin
    w_ff_found = 1'b0;
    w_ff_ch    = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_ff_found = 1'b1;
        w_ff_ch    = CH_W'(i);
      end
    end
  end

  assign w_ff_oh     = N_CH'(1) << w_ff_ch;
  assign w_ch_oh     = N_CH'(1) << r_ch;
  assign w_avg_clamp = (32'(i_avg_log2) > N_AVG_MAX_LOG2) ? N_AVG_W'(N_AVG_MAX_LOG2) : i_avg_log2;
  assign w_iter_nxt  = r_iter + IT_W'(1);
  assign w_iter_tgt  = IT_W'(1) << r_avg_log2;
  assign w_to_nxt    = r_to_cnt + N_TO'(1);
  assign w_to_hit    = (r_to_thr != '0) && (w_to_nxt == r_to_thr);
  assign w_rdy       = i_fcal_ready[r_ch];
  assign w_cnt_sel   = i_fcal_cnt[r_ch*N_FCAL_CNT +: N_FCAL_CNT];
  assign w_acc_clr   = (r_state == StSel) && w_ff_found;
  assign w_acc_add   = (r_state == StReq) && w_rdy && !i_abort;

  mdll_fcal_acc #(
    .N_CNT          (N_FCAL_CNT),
    .N_AVG_MAX_LOG2 (N_AVG_MAX_LOG2),
    .N_AVG_W        (N_AVG_W)
  ) u_acc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_acc_clr),
    .i_add      (w_acc_add),
    .i_val      (w_cnt_sel),
    .i_avg_log2 (r_avg_log2),
    .o_avg      (w_avg)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_mask         <= '0;
      r_ch           <= '0;
      r_avg_log2     <= '0;
      r_to_thr       <= '0;
      r_to_cnt       <= '0;
      r_iter         <= '0;
      r_en_fcal      <= '0;
      r_fcal_start   <= '0;
      r_result       <= '0;
      r_result_valid <= '0;
      r_err          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort wins over any ready/timeout event in the same cycle.
      if (i_abort && (r_state != StIdle)) begin
        r_state      <= StIdle;
        r_en_fcal    <= '0;
        r_fcal_start <= '0;
        r_to_cnt     <= '0;
        r_busy       <= 1'b0;
        r_done       <= 1'b1;
      end else begin
        case (r_state)
          StIdle: begin
            if (i_start) begin
              r_mask         <= i_ch_mask;
              r_avg_log2     <= w_avg_clamp;
              r_to_thr       <= i_timeout_cyc;
              r_result_valid <= '0;
              r_err          <= '0;
              r_busy         <= 1'b1;
              r_state        <= StSel;
            end
          end
          StSel: begin
            if (w_ff_found) begin
              r_ch         <= w_ff_ch;
              r_en_fcal    <= w_ff_oh;
              r_fcal_start <= w_ff_oh;
              r_iter       <= '0;
              r_to_cnt     <= '0;
              r_state      <= StReq;
            end else begin
              r_state <= StFin;
            end
          end
          StReq, StRel: begin
            if ((r_state == StReq) && w_rdy) begin
              r_fcal_start <= '0;
              r_to_cnt     <= '0;
              r_state      <= StRel;
            end else if ((r_state == StRel) && !w_rdy) begin
              r_iter   <= w_iter_nxt;
              r_to_cnt <= '0;
              if (w_iter_nxt == w_iter_tgt) begin
                r_state <= StStore;
              end else begin
                r_fcal_start <= w_ch_oh;
                r_state      <= StReq;
              end
            end else if (w_to_hit) begin
              r_err[r_ch]                             <= 1'b1;
              r_result[r_ch*N_FCAL_CNT +: N_FCAL_CNT] <= '1;
              r_fcal_start                            <= '0;
              r_en_fcal                               <= '0;
              r_mask[r_ch]                            <= 1'b0;
              r_state                                 <= StSel;
            end else begin
              r_to_cnt <= w_to_nxt;
            end
          end
          StStore: begin
            r_result[r_ch*N_FCAL_CNT +: N_FCAL_CNT] <= w_avg;
            r_result_valid[r_ch]                    <= 1'b1;
            r_en_fcal                               <= '0;
            r_mask[r_ch]                            <= 1'b0;
            r_state                                 <= StSel;
          end
          StFin: begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_en_fcal      = r_en_fcal;
  assign o_fcal_start   = r_fcal_start;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_err          = r_err;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule
